// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a parallel-in/serial-out transmitter.
// Frames go out MSB first, followed by a programmable idle gap.
module piso_tx_arbiter #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sdout,
  output logic             sframe,
  output logic             grant_id,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int              BIT_W    = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;
  logic             last_grant;

  logic             idle;
  logic             sel;
  logic             take;
  logic [WIDTH-1:0] take_data;

  // On a tie the requester that did not win last time is selected.
  assign idle       = (state == ST_IDLE);
  assign sel        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = idle && req0_valid && !sel;
  assign req1_ready = idle && req1_valid && sel;
  assign take       = req0_ready || req1_ready;
  assign take_data  = sel ? req1_data : req0_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      last_grant  <= 1'b1;
      sdout       <= 1'b0;
      sframe      <= 1'b0;
      grant_id    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            state      <= ST_SHIFT;
            busy       <= 1'b1;
            sdout      <= take_data[WIDTH-1];
            sframe     <= 1'b1;
            shreg      <= {take_data[WIDTH-2:0], 1'b0};
            bit_cnt    <= LAST_BIT;
            last_grant <= sel;
            grant_id   <= sel;
          end
        end
        ST_SHIFT: begin
          // bit_cnt counts the bits still to present after the one on sdout.
          if (bit_cnt == '0) begin
            sdout       <= 1'b0;
            sframe      <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + CNT_W'(1);
            if (GAP == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else begin
            sdout   <= shreg[WIDTH-1];
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - BIT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter: one instance at WIDTH=8/GAP=2 and one
// at WIDTH=8/GAP=0/CNT_W=2 for back-to-back frames and counter wrap.
module tb_piso_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;

  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       sdout, sframe, grant_id, busy, frame_done;
  logic [15:0] frame_count;

  logic       b_req0_valid, b_req1_valid;
  logic [7:0] b_req0_data, b_req1_data;
  logic       b_req0_ready, b_req1_ready;
  logic       b_sdout, b_sframe, b_grant_id, b_busy, b_frame_done;
  logic [1:0] b_frame_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_tx_arbiter #(.WIDTH(8), .GAP(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sdout(sdout), .sframe(sframe), .grant_id(grant_id), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  piso_tx_arbiter #(.WIDTH(8), .GAP(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .sdout(b_sdout), .sframe(b_sframe), .grant_id(b_grant_id), .busy(b_busy),
    .frame_done(b_frame_done), .frame_count(b_frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait for a frame on dut_a, check owner and all 8 bits, then the done pulse.
  task automatic expect_frame(input logic id, input logic [7:0] d);
    int k = 0;
    while (!sframe && k < 30) begin
      step();
      k++;
    end
    check("frame_start_timeout", 32'(k < 30), 32'd1);
    check("frame_grant", 32'(grant_id), 32'(id));
    for (int i = 0; i < 8; i++) begin
      check("frame_bit", 32'(sdout), 32'(d[7-i]));
      check("frame_sframe", 32'(sframe), 32'd1);
      step();
    end
    check("frame_done", 32'(frame_done), 32'd1);
    check("frame_sframe_low", 32'(sframe), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_data = '0; b_req1_data = '0;
    step();
    step();

    // Reset values
    check("rst_sdout", 32'(sdout), 32'd0);
    check("rst_sframe", 32'(sframe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);

    // Single frame 8'hA5 from req0, handshake on the first edge after release
    d = 8'hA5;
    req0_valid = 1'b1;
    req0_data  = d;
    reset      = 1'b0;
    #1;
    check("a5_ready_pre", 32'(req0_ready), 32'd1);
    step();
    for (int c = 1; c <= 11; c++) begin
      check("a5_sframe", 32'(sframe), 32'(c >= 1 && c <= 8));
      check("a5_sdout", 32'(sdout), (c <= 8) ? 32'(d[8-c]) : 32'd0);
      check("a5_busy", 32'(busy), 32'(c <= 10));
      check("a5_frame_done", 32'(frame_done), 32'(c == 9));
      check("a5_grant_id", 32'(grant_id), 32'd0);
      check("a5_frame_count", 32'(frame_count), (c >= 9) ? 32'd1 : 32'd0);
      check("a5_ready", 32'(req0_ready), 32'(c == 11));
      if (c < 11) step();
    end
    req0_valid = 1'b0;

    // Both requesters valid: round-robin 0,1,0,1
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h01;
    req1_valid = 1'b1; req1_data = 8'h80;
    expect_frame(1'b0, 8'h01);
    expect_frame(1'b1, 8'h80);
    expect_frame(1'b0, 8'h01);
    expect_frame(1'b1, 8'h80);
    check("rr_frame_count", 32'(frame_count), 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // req1 alone, req0 raised mid-frame must wait for the next IDLE cycle
    do_reset();
    req1_valid = 1'b1; req1_data = 8'h3C;
    step();
    check("late_grant1", 32'(grant_id), 32'd1);
    check("late_sframe1", 32'(sframe), 32'd1);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hC3;
    #1;
    for (int c = 1; c <= 10; c++) begin
      check("late_ready0_blocked", 32'(req0_ready), 32'd0);
      step();
    end
    check("late_ready0_idle", 32'(req0_ready), 32'd1);
    step();
    check("late_grant0", 32'(grant_id), 32'd0);
    check("late_first_bit", 32'(sdout), 32'd1);
    req0_valid = 1'b0;

    // Abort an 8'hFF frame after its 3rd bit
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hFF;
    step();
    req0_valid = 1'b0;
    step();
    step();
    check("abort_bit3", 32'(sdout), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_sdout", 32'(sdout), 32'd0);
    check("abort_sframe", 32'(sframe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("abort_no_done", 32'(frame_done), 32'd0);
      check("abort_count", 32'(frame_count), 32'd0);
    end
    req0_valid = 1'b1; req0_data = 8'h81;
    reset = 1'b0;
    #1;
    check("abort_ready_after", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    check("abort_restart_sframe", 32'(sframe), 32'd1);
    check("abort_restart_bit", 32'(sdout), 32'd1);
    for (int c = 1; c < 9; c++) step();
    check("abort_restart_done", 32'(frame_done), 32'd1);
    check("abort_restart_count", 32'(frame_count), 32'd1);

    // GAP=0, CNT_W=2: one idle cycle between frames, counter wraps
    d = 8'h5A;
    b_req0_valid = 1'b1; b_req0_data = d;
    step();
    for (int f = 1; f <= 4; f++) begin
      for (int i = 0; i < 8; i++) begin
        check("g0_sframe", 32'(b_sframe), 32'd1);
        check("g0_sdout", 32'(b_sdout), 32'(d[7-i]));
        step();
      end
      check("g0_gap_sframe", 32'(b_sframe), 32'd0);
      check("g0_frame_done", 32'(b_frame_done), 32'd1);
      check("g0_frame_count", 32'(b_frame_count), 32'(f % 4));
      if (f == 4) b_req0_valid = 1'b0;
      step();
    end
    check("g0_idle_after", 32'(b_sframe), 32'd0);
    check("g0_busy_after", 32'(b_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_tx_arbiter.md
PISO_TX_ARBITER -- requirements
Module: piso_tx_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, sets the frame width in bits; legal range 2..32.
REQ-002 Parameter GAP, default 1, sets the idle cycles inserted after each frame; legal range 0..15.
REQ-003 Parameter CNT_W, default 16, sets the width of the frame counter; legal range 2..32.
REQ-004 clk  input  1  Clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  Reset; asynchronous, active-high.
REQ-006 req0_valid  input  1  Requester 0 has a frame to send.
REQ-007 req0_data  input  WIDTH  Requester 0 parallel frame data.
REQ-008 req0_ready  output  1  Requester 0 frame accepted this cycle when req0_valid is also high.
REQ-009 req1_valid, req1_data, req1_ready  in/in/out  1/WIDTH/1  Same meanings as REQ-006..008, for requester 1.
REQ-010 sdout  output  1  Serial data, MSB first.
REQ-011 sframe  output  1  High while sdout carries a valid frame bit.
REQ-012 grant_id  output  1  Requester owning the current or most recent frame.
REQ-013 busy  output  1  High whenever the state is not IDLE.
REQ-014 frame_done  output  1  One-cycle pulse on frame completion.
REQ-015 frame_count  output  CNT_W  Number of completed frames, modulo 2^CNT_W.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and GAP.
REQ-017 Arbitration in IDLE: only one valid -> grant it; both valid -> grant the requester not equal to last_grant (round-robin).
REQ-018 reqN_ready SHALL be combinational, high only when the state is IDLE and requester N is the current selection; it SHALL be low in SHIFT and GAP.
REQ-019 Handshake SHALL occur at an edge where reqN_valid and reqN_ready are both high. On that edge: capture reqN_data into the internal shift register, set last_grant and grant_id to N, and enter SHIFT.
REQ-020 Requesters SHALL hold valid and data stable until handshake; data is not sampled at any other time.
REQ-021 Latency: in the first SHIFT cycle after handshake, sdout SHALL equal data[WIDTH-1] and sframe=1.
REQ-022 SHIFT SHALL last exactly WIDTH cycles, presenting one bit per cycle from MSB to LSB, tracked by a bit counter.
REQ-023 After the last bit the FSM SHALL enter GAP for GAP cycles, or go directly to IDLE if GAP=0.
REQ-024 Outside SHIFT, sdout=0 and sframe=0.
REQ-025 frame_done SHALL be high for exactly one cycle: the cycle immediately following the last SHIFT cycle.
REQ-026 frame_count SHALL increment by 1 in that same cycle, wrapping from 2^CNT_W-1 to 0.
REQ-027 Consecutive frames SHALL be separated by at least 1+GAP cycles with sframe=0 (GAP cycles plus the IDLE handshake cycle).
REQ-028 Valid signals that change while the FSM is in SHIFT or GAP SHALL have no effect until the next IDLE cycle.
REQ-029 sdout, sframe, grant_id, busy, frame_done and frame_count SHALL be registered outputs.

Reset
REQ-030 Asserting reset at any time SHALL force the following values: state=IDLE, sdout=0, sframe=0, busy=0, frame_done=0, grant_id=0, last_grant=1 (so req0 wins the first tie), frame_count=0, shift register=0 and bit counter=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame: no frame_done pulse and no count increment.
REQ-032 The first handshake SHALL be possible in the first cycle after reset deasserts.

Verification (WIDTH=8, GAP=2 unless stated; cycle 0 = handshake edge)
REQ-033 req0_valid held with req0_data=8'hA5 -> sframe=1 in cycles 1-8, sdout=1,0,1,0,0,1,0,1, grant_id=0, frame_done=1 in cycle 9, frame_count=1, busy=1 in cycles 1-10, req0_ready high again in cycle 11.
REQ-034 Both valid continuously, req0=8'h01, req1=8'h80 -> grants 0,1,0,1; each frame's sdout matches its requester's data; frame_count=4 after the fourth frame_done.
REQ-035 Only req1 valid, then req0 raised during req1's SHIFT -> req0_ready=0 until the next IDLE cycle, then req0 is granted (last_grant=1).
REQ-036 Reset asserted after the 3rd bit of 8'hFF -> sdout=0, sframe=0, busy=0 immediately; frame_done never pulses; frame_count stays 0; a new handshake is accepted on the first cycle after release.
REQ-037 GAP=0, CNT_W=2, req0 valid continuously -> exactly 1 cycle with sframe=0 between frames; frame_count reads 1,2,3,0 after frames 1-4.
